// File: rtl/key_debounce_multi_if.sv
// Pushbutton bundle between raw board inputs and the game logic.
// 'release' is a reserved word in SystemVerilog. The release pulse is
// therefore carried as release_pulse.
// The debouncer takes the slave modport. The consumer that drives the
// raw keys and reads the events takes the master modport.
interface key_debounce_multi_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] release_pulse;
    logic              any_press;

    modport master (
        output key_raw,
        input  level,
        input  press,
        input  release_pulse,
        input  any_press
    );

    modport slave (
        input  key_raw,
        output level,
        output press,
        output release_pulse,
        output any_press
    );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel pushbutton debouncer.
// Each channel does three things:
//   - Synchronises its raw input through two flops.
//   - Debounces it on a sample tick shared by all channels.
//   - Emits a debounced level plus one-cycle press and release pulses.
// Optional auto-repeat is enabled by defining the macro KEY_REPEAT_EN.
// Auto-repeat emits extra press pulses while a key stays held.
// Reset is asynchronous and active high.
module key_debounce_multi #(
    parameter int N_KEYS       = 4,
    parameter int SAMPLE_DIV   = 128,
    parameter int STABLE_CNT   = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input logic                  clk,
    input logic                  reset,
    key_debounce_multi_if.slave  keys
);

    // Raw value of a key that is not pressed. The synchroniser resets
    // to this value so that no spurious press is seen after reset.
    localparam logic [N_KEYS-1:0] RAW_IDLE =
        (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    localparam int CW = $clog2(STABLE_CNT + 1);
    // Counter value at which the next disagreeing sample completes
    // qualification.
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CNT - 1);

    logic [N_KEYS-1:0] sync1_reg;
    logic [N_KEYS-1:0] sync2_reg;
    logic [N_KEYS-1:0] key_s;          // synchronised, 1 = pressed
    logic              tick;

    logic [N_KEYS-1:0] level_vec;
    logic [N_KEYS-1:0] press_vec;
    logic [N_KEYS-1:0] release_vec;
    logic [N_KEYS-1:0] press_next_vec;
    logic              any_press_reg;

    // Two-flop synchroniser per channel, preloaded with the idle raw value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= RAW_IDLE;
            sync2_reg <= RAW_IDLE;
        end else begin
            sync1_reg <= keys.key_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Polarity is normalised after the synchroniser.
    // Everything downstream then works with 1 = pressed.
    assign key_s = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

    // Shared sample prescaler.
    // With SAMPLE_DIV of 1 every cycle is a sample, so no counter exists.
    generate
        if (SAMPLE_DIV == 1) begin : g_no_presc
            assign tick = 1'b1;
        end else begin : g_presc
            localparam int PW = $clog2(SAMPLE_DIV);
            localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);

            logic [PW-1:0] presc_reg;

            assign tick = (presc_reg == PRESC_LAST);

            // Free-running 0..SAMPLE_DIV-1 counter.
            // Wrapping on tick keeps the tick period exact.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    presc_reg <= '0;
                end else if (tick) begin
                    presc_reg <= '0;
                end else begin
                    presc_reg <= presc_reg + 1'b1;
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
            logic [CW-1:0] stab_cnt_reg;
            logic [CW-1:0] stab_cnt_next;
            logic          level_bit_reg;
            logic          level_next;
            logic          press_bit_reg;
            logic          release_bit_reg;
            logic          flip;

            // Qualification logic, split into three cases:
            //   - A disagreeing sample advances the counter.
            //   - An agreeing sample restarts qualification.
            //   - Between ticks the counter holds its value.
            always_comb begin
                stab_cnt_next = stab_cnt_reg;
                level_next    = level_bit_reg;
                flip          = 1'b0;
                if (tick) begin
                    if (key_s[gi] != level_bit_reg) begin
                        if (stab_cnt_reg == STABLE_LAST) begin
                            flip          = 1'b1;
                            level_next    = ~level_bit_reg;
                            stab_cnt_next = '0;
                        end else begin
                            stab_cnt_next = stab_cnt_reg + 1'b1;
                        end
                    end else begin
                        stab_cnt_next = '0;
                    end
                end
            end

`ifdef KEY_REPEAT_EN
            localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int RW   = $clog2(RMAX + 1);
            localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

            logic [RW-1:0] rep_cnt_reg;
            logic [RW-1:0] rep_cnt_next;
            logic          rep_phase_reg;   // 0: waiting for first delay, 1: steady rate
            logic          rep_phase_next;
            logic          rep_fire;

            // Auto-repeat timer behaviour:
            //   - It starts from zero on every level edge.
            //   - It runs per tick while the key is held.
            //   - It fires only while no level edge is occurring, so a
            //     release cycle can never carry a repeat pulse.
            always_comb begin
                rep_cnt_next   = rep_cnt_reg;
                rep_phase_next = rep_phase_reg;
                rep_fire       = 1'b0;
                if (flip || !level_bit_reg) begin
                    rep_cnt_next   = '0;
                    rep_phase_next = 1'b0;
                end else if (tick) begin
                    if (rep_cnt_reg == (rep_phase_reg ? RATE_LAST : DELAY_LAST)) begin
                        rep_fire       = 1'b1;
                        rep_cnt_next   = '0;
                        rep_phase_next = 1'b1;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + 1'b1;
                    end
                end
            end

            // Auto-repeat state register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rep_cnt_reg   <= '0;
                    rep_phase_reg <= 1'b0;
                end else begin
                    rep_cnt_reg   <= rep_cnt_next;
                    rep_phase_reg <= rep_phase_next;
                end
            end

            assign press_next_vec[gi] = (flip && level_next) || rep_fire;
`else
            assign press_next_vec[gi] = flip && level_next;
`endif

            // Level and pulse registers.
            // The pulses load on the same edge as the level flip, so they
            // line up with the first cycle of the new level.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stab_cnt_reg    <= '0;
                    level_bit_reg   <= 1'b0;
                    press_bit_reg   <= 1'b0;
                    release_bit_reg <= 1'b0;
                end else begin
                    stab_cnt_reg    <= stab_cnt_next;
                    level_bit_reg   <= level_next;
                    press_bit_reg   <= press_next_vec[gi];
                    release_bit_reg <= flip && !level_next;
                end
            end

            assign level_vec[gi]   = level_bit_reg;
            assign press_vec[gi]   = press_bit_reg;
            assign release_vec[gi] = release_bit_reg;
        end
    endgenerate

    // any_press is registered from the same next-state term as press.
    // This keeps it cycle-aligned with the individual press outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_press_reg <= 1'b0;
        end else begin
            any_press_reg <= |press_next_vec;
        end
    end

    assign keys.level         = level_vec;
    assign keys.press         = press_vec;
    assign keys.release_pulse = release_vec;
    assign keys.any_press     = any_press_reg;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi.
// Configuration: 2 keys, SAMPLE_DIV=4, STABLE_CNT=3, active-low.
// The repeat section follows the KEY_REPEAT_EN macro.
module tb_key_debounce_multi;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    key_debounce_multi_if #(.N_KEYS(2)) kif();

    key_debounce_multi #(
        .N_KEYS(2),
        .SAMPLE_DIV(4),
        .STABLE_CNT(3),
        .ACTIVE_LOW(1),
        .REPEAT_DELAY(8),
        .REPEAT_RATE(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys(kif)
    );

    typedef struct {
        logic [1:0] raw;
        int         cycles;
        logic [1:0] exp_level;
        int         exp_press0;
        int         exp_press1;
        int         exp_rel0;
        int         exp_rel1;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int press_cnt0, press_cnt1, rel_cnt0, rel_cnt1;
    logic [1:0] level_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clear_counts();
        press_cnt0 = 0; press_cnt1 = 0; rel_cnt0 = 0; rel_cnt1 = 0;
        level_seen = 2'b00;
    endtask

    // One clock: sample 1 time unit after the edge, accumulate pulses,
    // check per-cycle invariants.
    task automatic step();
        @(posedge clk);
        #1;
        press_cnt0 += int'(kif.press[0]);
        press_cnt1 += int'(kif.press[1]);
        rel_cnt0   += int'(kif.release_pulse[0]);
        rel_cnt1   += int'(kif.release_pulse[1]);
        level_seen |= kif.level;
        checks++;
        if ((kif.press & kif.release_pulse) != 2'b00) begin
            errors++;
            $display("FAIL press_and_release_together: press=%b release=%b required disjoint",
                     kif.press, kif.release_pulse);
        end
        checks++;
        if (kif.any_press !== (kif.press != 2'b00)) begin
            errors++;
            $display("FAIL any_press_or: any_press=%b press=%b", kif.any_press, kif.press);
        end
    endtask

    task automatic hold(input logic [1:0] raw, input int n);
        kif.key_raw = raw;
        for (int k = 0; k < n; k++) step();
    endtask

    vec_t vecs[6];

    initial begin
        int rise_at, first_rel, last_p;
        int gaps[$];

        vecs[0] = '{2'b11, 20, 2'b00, 0, 0, 0, 0};
        vecs[1] = '{2'b10, 20, 2'b01, 1, 0, 0, 0};
        vecs[2] = '{2'b00, 20, 2'b11, 0, 1, 0, 0};
        vecs[3] = '{2'b11, 20, 2'b00, 0, 0, 1, 1};
        vecs[4] = '{2'b01, 20, 2'b10, 0, 1, 0, 0};
        vecs[5] = '{2'b11, 20, 2'b00, 0, 0, 0, 1};

        // Reset with keys released.
        reset = 1'b1;
        kif.key_raw = 2'b11;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("reset_level", kif.level, 2'b00);
        check("reset_press", kif.press, 2'b00);
        check("reset_release", kif.release_pulse, 2'b00);
        check("reset_any_press", kif.any_press, 1'b0);
        reset = 1'b0;
        hold(2'b11, 20);
        check("idle_level_seen", level_seen, 2'b00);
        check("idle_pulses", press_cnt0 + press_cnt1 + rel_cnt0 + rel_cnt1, 0);
        $display("reset: level=%b checks=%0d", kif.level, checks);

        // Clean press on key 0.
        clear_counts();
        kif.key_raw = 2'b10;
        rise_at = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (rise_at == 0 && kif.level[0] === 1'b1) begin
                rise_at = n;
                check("press_coincident", kif.press, 2'b01);
                check("any_press_coincident", kif.any_press, 1'b1);
            end
        end
        check_range("press_latency", rise_at, 11, 14);
        check("clean_press_level", kif.level, 2'b01);
        check("clean_press_count0", press_cnt0, 1);
        check("clean_press_ch1_quiet", press_cnt1 + rel_cnt1, 0);
        $display("clean press: level rose after %0d cycles", rise_at);

        // Release key 0.
        clear_counts();
        hold(2'b11, 20);
        check("release_level", kif.level, 2'b00);
        check("release_count0", rel_cnt0, 1);

        // Short glitch must be rejected.
        clear_counts();
        hold(2'b10, 5);
        hold(2'b11, 35);
        check("glitch_level_seen", level_seen, 2'b00);
        check("glitch_pulses", press_cnt0 + press_cnt1 + rel_cnt0 + rel_cnt1, 0);
        $display("glitch: level_seen=%b", level_seen);

        // Table of settled vectors.
        foreach (vecs[v]) begin
            clear_counts();
            hold(vecs[v].raw, vecs[v].cycles);
            check($sformatf("vec%0d_level", v), kif.level, vecs[v].exp_level);
            check($sformatf("vec%0d_press0", v), press_cnt0, vecs[v].exp_press0);
            check($sformatf("vec%0d_press1", v), press_cnt1, vecs[v].exp_press1);
            check($sformatf("vec%0d_rel0", v), rel_cnt0, vecs[v].exp_rel0);
            check($sformatf("vec%0d_rel1", v), rel_cnt1, vecs[v].exp_rel1);
            $display("vec%0d: raw=%b level=%b press=%0d/%0d rel=%0d/%0d", v, vecs[v].raw,
                     kif.level, press_cnt0, press_cnt1, rel_cnt0, rel_cnt1);
        end

        // Simultaneous release of both keys.
        hold(2'b00, 20);
        check("both_pressed_level", kif.level, 2'b11);
        clear_counts();
        kif.key_raw = 2'b11;
        first_rel = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (first_rel == 0 && kif.release_pulse != 2'b00) begin
                first_rel = n;
                check("simul_release_common", kif.release_pulse, 2'b11);
            end
        end
        check_range("simul_release_seen", first_rel, 11, 14);
        check("simul_release_level", kif.level, 2'b00);
        check("simul_release_counts", rel_cnt0 * 16 + rel_cnt1, 17);
        $display("simultaneous release at cycle %0d", first_rel);

        // Bouncing release: exactly one release per channel.
        hold(2'b00, 20);
        clear_counts();
        for (int k = 0; k < 8; k++) hold((k % 2 == 0) ? 2'b11 : 2'b00, 2);
        hold(2'b11, 30);
        check("bounce_level", kif.level, 2'b00);
        check("bounce_rel0", rel_cnt0, 1);
        check("bounce_rel1", rel_cnt1, 1);
        check("bounce_press", press_cnt0 + press_cnt1, 0);
        $display("bounce: rel=%0d/%0d press=%0d/%0d", rel_cnt0, rel_cnt1, press_cnt0, press_cnt1);

        // Reset in the middle of qualification.
        clear_counts();
        hold(2'b10, 6);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("midreset_level", kif.level, 2'b00);
        check("midreset_pulses", press_cnt0 + press_cnt1 + rel_cnt0 + rel_cnt1, 0);
        reset = 1'b0;
        clear_counts();
        hold(2'b10, 14);
        check("midreset_press_once", press_cnt0, 1);
        check("midreset_level_after", kif.level, 2'b01);
        $display("reset mid-qualification: press0 count=%0d", press_cnt0);
        hold(2'b11, 20);

        // Held key: repeat pulses, or a single press when repeat is absent.
        clear_counts();
        kif.key_raw = 2'b10;
        last_p = -1;
        for (int n = 1; n <= 70; n++) begin
            step();
            if (kif.press[0] === 1'b1) begin
                if (last_p >= 0) gaps.push_back(n - last_p);
                last_p = n;
            end
        end
`ifdef KEY_REPEAT_EN
        check("repeat_gap_count_ge3", (gaps.size() >= 3) ? 1 : 0, 1);
        check("repeat_gap0", (gaps.size() > 0) ? gaps[0] : -1, 32);
        check("repeat_gap1", (gaps.size() > 1) ? gaps[1] : -1, 8);
        check("repeat_gap2", (gaps.size() > 2) ? gaps[2] : -1, 8);
`else
        check("no_repeat_press_once", press_cnt0, 1);
`endif
        $display("held key: press0 count=%0d gaps=%0d", press_cnt0, gaps.size());
        clear_counts();
        hold(2'b11, 40);
        check("held_release_once", rel_cnt0, 1);
        check("held_release_no_press", press_cnt0, 0);
        check("held_release_level", kif.level, 2'b00);
        $display("held key release: rel0=%0d press0=%0d", rel_cnt0, press_cnt0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised multi-channel successor to the single-key press detector.
- Sits between raw board pushbuttons and game logic, e.g. flap input and start/pause.
- Per channel: synchronises the raw input, debounces it on a shared sample tick, and outputs a debounced level plus one-cycle press and release pulses.
- Optional auto-repeat generates periodic press pulses while a key is held.

Parameters:
- N_KEYS, 4: number of independent key channels.
- SAMPLE_DIV, 128: clock cycles per sample tick; range >=1, and 1 means every cycle.
- STABLE_CNT, 4: consecutive differing samples required to flip the debounced state; range >=1.
- ACTIVE_LOW, 1: 1 means a raw 0 is "pressed"; 0 means a raw 1 is "pressed".
- REPEAT_DELAY, 64: ticks held before the first repeat press; used only with KEY_REPEAT_EN.
- REPEAT_RATE, 16: ticks between subsequent repeat presses; used only with KEY_REPEAT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- key_raw  in  N_KEYS  raw asynchronous pushbutton inputs.
- level  out  N_KEYS  debounced state; 1 = pressed.
- press  out  N_KEYS  one-cycle pulse on debounced press (and on repeat).
- release  out  N_KEYS  one-cycle pulse on debounced release.
- any_press  out  1  OR-reduction of press, same cycle.

Behaviour:
- Reset (async assert, sync deassert by the surrounding design):
  - level, press and release are 0; any_press is 0.
  - Synchroniser flops load the "released" raw value, i.e. ACTIVE_LOW ? 1 : 0.
  - Prescaler and all stability/repeat counters are 0.
- Synchroniser: two flops per channel. Inversion by ACTIVE_LOW is applied after the synchroniser, giving the internal signal s[i] (1 = pressed).
- Prescaler:
  - Width is $clog2(SAMPLE_DIV), minimum 1.
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick = 1 in the cycle the count equals SAMPLE_DIV-1; tick is constant 1 when SAMPLE_DIV=1.
  - Shared by all channels.
- Per-channel debounce:
  - Stability counter width is $clog2(STABLE_CNT+1).
  - On a tick edge with s[i] != level[i]: counter increments. When the counter would reach STABLE_CNT, level[i] flips and the counter clears.
  - On a tick edge with s[i] == level[i]: counter clears. Any agreeing sample restarts qualification.
  - Not a tick: counter holds.
- Pulses:
  - press[i] is registered and high for exactly the one cycle coinciding with the first cycle of level[i]=1.
  - release[i] behaves the same for the first cycle of level[i]=0.
  - press and release are never high together on one channel.
- Latency: from a raw change held stable until the flip, level changes between 2+(STABLE_CNT-1)*SAMPLE_DIV+1 and 2+STABLE_CNT*SAMPLE_DIV cycles later.
- Glitch rejection: a raw excursion spanning fewer than STABLE_CNT tick edges produces no level change and no pulse.
- Channel independence: channels are fully independent. Any subset may pulse in the same cycle; any_press then is 1 for that cycle.
- Key held through reset: after reset deasserts, the key qualifies normally, and level rise plus a press pulse occur within the latency bound.
- Reset mid-qualification: progress is discarded; no pulse is emitted during or at the reset edge.
- Prescaler wrap: no tick is skipped or duplicated at wrap; the tick period is exactly SAMPLE_DIV cycles.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Each channel adds a repeat counter, width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1), cleared when level[i] rises.
  - While level[i]=1, the counter increments per tick.
  - On reaching REPEAT_DELAY: press[i] pulses for one cycle and the counter reloads to 0 with REPEAT_RATE as the new target. Subsequent pulses come every REPEAT_RATE ticks.
  - On release: counter and target reset; no repeat pulse in the release cycle.
  - Repeat pulses also drive any_press.
- Undefined: no repeat logic is synthesised; press fires only on the debounced rising edge.

Test Plan:
- Bench uses N_KEYS=2, SAMPLE_DIV=4, STABLE_CNT=3, ACTIVE_LOW=1.
- Reset: assert reset with key_raw=2'b11 -> level=0, press=0, release=0, any_press=0; outputs stay 0 for 20 cycles after deassert.
- Clean press: drive key_raw[0]=0 and hold -> level[0] rises 11..14 cycles later; press[0]=1 for exactly 1 cycle, coincident with it; any_press=1 in that cycle; channel 1 unaffected.
- Glitch: key_raw[0]=0 for 5 cycles, then 1 -> no level change; press=0 and release=0 throughout 40 cycles.
- Release and simultaneity:
  - With both keys pressed, set key_raw=2'b11 on the same cycle -> release=2'b11 for one common cycle, level returns to 2'b00.
  - Bounce 0/1/0 every 2 cycles for 16 cycles before settling -> exactly one release per channel.
- Reset mid-operation: assert reset 6 cycles into a press qualification while holding key_raw[0]=0 -> no pulse during reset; after deassert, press[0] fires once within 14 cycles.
- With KEY_REPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=2: hold key 0 -> initial press, then a press 32 cycles later, then every 8 cycles; releasing gives one release and no further press.
